// File: rtl/cur_buffer.sv
// ============================================================================
// cur_buffer: assembles an 8x8 block of 8-bit pixels from 16 32-bit words.
// Optional macro CURBUF_DBUF_EN: fill a shadow register, publish it all at once.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cur_buffer (
  input  logic         clk,
  input  logic         rst,
  input  logic         next_block,
  input  logic [31:0]  cur_in,
  output logic [511:0] cur_out,
  output logic         need_cur
);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_cnt;
  logic [511:0] r_cur;
  logic         w_last_word;
  logic [8:0]   w_slice_lsb;

  assign w_last_word = (r_state == S_FILL) && (r_cnt == 4'd15);
  assign w_slice_lsb = {r_cnt, 5'd0};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (r_cnt == 4'd15) w_state_nxt = S_HOLD;
      S_HOLD:  if (next_block)     w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FILL;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      // The 4-bit counter wraps to 0 on its own after word 15
      if (r_state == S_FILL) r_cnt <= r_cnt + 4'd1;
      else                   r_cnt <= 4'd0;
    end
  end

`ifdef CURBUF_DBUF_EN
  logic [511:0] r_shadow;
  logic [511:0] w_shadow_nxt;

  always_comb begin
    w_shadow_nxt = r_shadow;
    w_shadow_nxt[w_slice_lsb +: 32] = cur_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow <= '0;
      r_cur    <= '0;
    end else if (r_state == S_FILL) begin
      r_shadow <= w_shadow_nxt;
      // Word 15 goes straight from the input into the published block
      if (w_last_word) r_cur <= w_shadow_nxt;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur <= '0;
    end else if (r_state == S_FILL) begin
      r_cur[w_slice_lsb +: 32] <= cur_in;
    end
  end
`endif

  assign cur_out  = r_cur;
  assign need_cur = (r_state == S_FILL);

endmodule

`default_nettype wire

// File: tb/tb_cur_buffer.sv
// Table-driven bench for cur_buffer with a behavioural reference model and an
// expected-value queue; hand sequences cover async reset and fill overlap.
`default_nettype none

module tb_cur_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         next_block = 1'b0;
  logic [31:0]  cur_in = '0;
  logic [511:0] cur_out;
  logic         need_cur;

  cur_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .next_block (next_block),
    .cur_in     (cur_in),
    .cur_out    (cur_out),
    .need_cur   (need_cur)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        nb;
    logic [31:0] din;
    logic        exp_need;
  } vec_t;

  typedef struct {
    logic         need;
    logic [511:0] cur;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic         m_fill;
  logic [3:0]   m_cnt;
  logic [511:0] m_cur;
  logic [511:0] m_sh;

  function automatic logic [31:0] word_of(input int base, input int n);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'(base + 4*n + b);
    return w;
  endfunction

  function automatic logic [511:0] block_of(input int base);
    logic [511:0] blk;
    for (int k = 0; k < 64; k++) blk[8*k +: 8] = 8'(base + k);
    return blk;
  endfunction

  function automatic void add(input logic nb, input logic [31:0] din, input logic need);
    vec_t v;
    v.nb = nb; v.din = din; v.exp_need = need;
    vecs.push_back(v);
  endfunction

  function automatic void add_fill(input int base, input int nb_word);
    for (int n = 0; n < 16; n++) add(n == nb_word, word_of(base, n), n != 15);
  endfunction

  function automatic void chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endfunction

  function automatic void model_reset();
    m_fill = 1'b1; m_cnt = 4'd0; m_cur = '0; m_sh = '0;
  endfunction

  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    next_block = v.nb;
    cur_in     = v.din;
    if (m_fill) begin
`ifdef CURBUF_DBUF_EN
      m_sh[32*m_cnt +: 32] = v.din;
      if (m_cnt == 4'd15) m_cur = m_sh;
`else
      m_cur[32*m_cnt +: 32] = v.din;
`endif
      if (m_cnt == 4'd15) m_fill = 1'b0;
      m_cnt = m_cnt + 4'd1;
    end else if (v.nb) begin
      m_fill = 1'b1;
      m_cnt  = 4'd0;
    end
    e.need = v.exp_need;
    e.cur  = m_cur;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk($sformatf("vec%0d need_cur", idx), 512'(need_cur), 512'(e.need));
    chk($sformatf("vec%0d cur_out", idx), cur_out, e.cur);
  endtask

  localparam int C2_WORD0 = 37;
  localparam int C_FILL1_END = 52;
  localparam int C_FILL2_END = 69;

  initial begin
    // Phase A: first fill after reset, byte value = pixel index
    add_fill(0, -1);
    // Phase B: 20 HOLD cycles with changing input
    for (int i = 0; i < 20; i++) add(1'b0, $urandom, 1'b0);
    // Phase C: one-cycle pulse, input on that cycle must not be captured
    add(1'b1, 32'hDEADBEEF, 1'b1);
    add_fill(64, -1);
    // Phase D: pulse, then a pulse at word 5 that must be ignored
    add(1'b1, 32'hCAFEF00D, 1'b1);
    add_fill(128, 5);
    for (int i = 0; i < 3; i++) add(1'b0, $urandom, 1'b0);
    // Phase E: start a fill that will be aborted by reset after 9 words
    add(1'b1, 32'h0BADF00D, 1'b1);
    for (int n = 0; n < 9; n++) add(1'b0, word_of(32, n), 1'b1);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset need_cur", 512'(need_cur), 512'(1'b1));
    chk("reset cur_out", cur_out, '0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
      if (i == 15) chk("block0 bytes", cur_out, block_of(0));
      if (i == C2_WORD0) begin
`ifdef CURBUF_DBUF_EN
        chk("dbuf word0 keeps old block", cur_out, block_of(0));
`else
        chk("direct word0 low slice new", 512'(cur_out[31:0]), 512'(word_of(64, 0)));
        chk("direct word0 upper old", 512'(cur_out[511:32]), 512'(block_of(0) >> 32));
`endif
      end
      if (i == C_FILL1_END) chk("block1 bytes", cur_out, block_of(64));
      if (i == C_FILL2_END) chk("block2 bytes", cur_out, block_of(128));
    end

    // Asynchronous reset in the middle of the aborted fill
    #3;
    rst = 1'b0;
    #1;
    chk("async reset cur_out", cur_out, '0);
    chk("async reset need_cur", 512'(need_cur), 512'(1'b1));
    @(posedge clk);
    #1;
    chk("held reset cur_out", cur_out, '0);
    rst = 1'b1;
    model_reset();

    vecs.delete();
    add_fill(192, -1);
    add(1'b0, 32'h12345678, 1'b0);
    for (int i = 0; i < vecs.size(); i++) apply(100 + i, vecs[i]);
    chk("block after reset bytes", cur_out, block_of(192));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
